// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory,
// and fills the IF/ID pipeline register. Handles decode stalls, EX
// redirects, and halting after a SYSTEM (ECALL/EBREAK) instruction.
module fetch_stage #(
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_data_i,
  output logic [31:0]        ifid_pc_o,
  output logic [31:0]        ifid_pc4_o,
  output logic [31:0]        ifid_inst_o,
  output logic               ifid_valid_o,
  output logic               halted_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t      state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] ifid_pc_q,    ifid_pc_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic [31:0] ifid_inst_q,  ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc_aligned;

  assign pc_plus4            = pc_q + 32'd4;
  // Low two target bits are dropped silently; there is no misalignment trap.
  assign redirect_pc_aligned = redirect_pc_i & ~32'h0000_0003;

  // Next-state: redirect beats stall, stall beats normal fetch/halt behaviour.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;

    if (redirect_i) begin
      // Flush: whatever was being fetched (even a SYSTEM word) is wrong-path.
      state_d      = ST_RUN;
      pc_d         = redirect_pc_aligned;
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end else if (!stall_i) begin
      ifid_pc_d  = pc_q;
      ifid_pc4_d = pc_plus4;
      if (state_q == ST_RUN) begin
        pc_d         = pc_plus4;
        ifid_inst_d  = imem_data_i;
        ifid_valid_d = 1'b1;
        if (imem_data_i[6:0] == OPC_SYSTEM) begin
          state_d = ST_HALT;
        end
      end else begin
        // Halted: PC parked, keep injecting bubbles.
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset discarding all in-flight state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Memory index wraps modulo 2^IMEM_AW; driven only from the PC register.
  assign imem_addr_o  = pc_q[IMEM_AW+1:2];
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_inst_o  = ifid_inst_q;
  assign ifid_valid_o = ifid_valid_q;
  assign halted_o     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;
  logic        halted_o;

  logic [31:0] mem [64];

  int errors = 0;
  int checks = 0;

  fetch_stage #(
    .IMEM_AW (6),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0033)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_inst_o  (ifid_inst_o),
    .ifid_valid_o (ifid_valid_o),
    .halted_o     (halted_o)
  );

  assign imem_data_i = mem[imem_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic vld);
    chk({tag, ".pc"},    ifid_pc_o,   pc);
    chk({tag, ".pc4"},   ifid_pc4_o,  (vld || pc != 32'd0) ? pc + 32'd4 : 32'd0);
    chk({tag, ".inst"},  ifid_inst_o, inst);
    chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, vld});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0000_0033;
    mem[1]  = 32'h0000_2083;
    mem[2]  = 32'h0010_0113;
    mem[3]  = 32'h0000_0073;   // ECALL at pc 0x0C
    mem[10] = 32'h00A0_0093;
    mem[63] = 32'h3F00_0013;

    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    #2;
    chk("rst.addr",   {26'd0, imem_addr_o}, 32'd0);
    chk_ifid("rst", 32'd0, 32'h0000_0033, 1'b0);
    chk("rst.halted", {31'd0, halted_o}, 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;

    // Straight-line fetch
    step();
    chk_ifid("c1", 32'h0, 32'h0000_0033, 1'b1);
    step();
    chk_ifid("c2", 32'h4, 32'h0000_2083, 1'b1);
    chk("c2.addr", {26'd0, imem_addr_o}, 32'd2);

    // Stall holds PC and IF/ID
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr", {26'd0, imem_addr_o}, 32'd2);
      chk_ifid("stall", 32'h4, 32'h0000_2083, 1'b1);
    end
    stall_i = 1'b0;
    step();
    chk_ifid("resume", 32'h8, 32'h0010_0113, 1'b1);

    // ECALL fetched, then halt
    step();
    chk_ifid("ecall", 32'hC, 32'h0000_0073, 1'b1);
    chk("ecall.halted", {31'd0, halted_o}, 32'd1);
    chk("ecall.addr", {26'd0, imem_addr_o}, 32'd4);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_ifid("halt", 32'h10, 32'h0000_0033, 1'b0);
      chk("halt.addr", {26'd0, imem_addr_o}, 32'd4);
      chk("halt.halted", {31'd0, halted_o}, 32'd1);
    end

    // Redirect out of HALT
    redirect_i = 1'b1; redirect_pc_i = 32'h4;
    step();
    redirect_i = 1'b0;
    chk("rdh.halted", {31'd0, halted_o}, 32'd0);
    chk("rdh.addr", {26'd0, imem_addr_o}, 32'd1);
    chk_ifid("rdh", 32'h0, 32'h0000_0033, 1'b0);
    step();
    chk_ifid("rdh2", 32'h4, 32'h0000_2083, 1'b1);

    // Redirect with stall, misaligned target
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_002A; stall_i = 1'b1;
    step();
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("rds.addr", {26'd0, imem_addr_o}, 32'd10);
    chk_ifid("rds", 32'h0, 32'h0000_0033, 1'b0);
    step();
    chk_ifid("rds2", 32'h28, 32'h00A0_0093, 1'b1);

    // Address wrap past the 64-word memory
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_00FC;
    step();
    redirect_i = 1'b0;
    chk("wrap.addr0", {26'd0, imem_addr_o}, 32'd63);
    step();
    chk_ifid("wrap1", 32'hFC, 32'h3F00_0013, 1'b1);
    chk("wrap.addr1", {26'd0, imem_addr_o}, 32'd0);
    step();
    chk_ifid("wrap2", 32'h100, 32'h0000_0033, 1'b1);

    // Redirect in the same cycle as a SYSTEM word is on the memory bus
    redirect_i = 1'b1; redirect_pc_i = 32'h0C;
    step();
    chk("sys.addr", {26'd0, imem_addr_o}, 32'd3);
    redirect_pc_i = 32'h20;
    step();
    redirect_i = 1'b0;
    chk("sysrd.halted", {31'd0, halted_o}, 32'd0);
    chk("sysrd.addr", {26'd0, imem_addr_o}, 32'd8);
    chk_ifid("sysrd", 32'h0, 32'h0000_0033, 1'b0);

    // Async reset while halted and stalled
    redirect_i = 1'b1; redirect_pc_i = 32'h0C;
    step();
    redirect_i = 1'b0;
    step();
    chk("pre.halted", {31'd0, halted_o}, 32'd1);
    stall_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.halted", {31'd0, halted_o}, 32'd0);
    chk("arst.addr", {26'd0, imem_addr_o}, 32'd0);
    chk_ifid("arst", 32'h0, 32'h0000_0033, 1'b0);
    step();
    rst = 1'b0; stall_i = 1'b0;
    step();
    chk_ifid("post", 32'h0, 32'h0000_0033, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
